// File: rtl/data_ext_pkg.sv
// Core-wide load funct3 encodings and the result bundle used by the load-data extender.
package data_ext_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [31:0] data;
    logic        illegal;
  } load_res_t;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/data_ext.sv
// Load-data extender: turns the raw DMEM read word into the RV32 write-back
// value for LB/LH/LW/LBU/LHU. Lane alignment is done upstream, so extraction
// always uses the low bits. Optional output register selected by OUT_REG.
module data_ext
  import data_ext_pkg::*;
#(
  parameter int OUT_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  opcode,
  input  logic [31:0] in_data,
  output logic [31:0] opt_data,
  output logic        illegal
);

  load_res_t res_d;

  // Decode funct3 and extract/extend the low byte or halfword; undefined
  // encodings return zero, matching the DMEM unmapped-region value.
  always_comb begin
    res_d = '0;
    case (opcode)
      F3_LB:   res_d.data = sext8(in_data[7:0]);
      F3_LH:   res_d.data = sext16(in_data[15:0]);
      F3_LW:   res_d.data = in_data;
      F3_LBU:  res_d.data = {24'b0, in_data[7:0]};
      F3_LHU:  res_d.data = {16'b0, in_data[15:0]};
      default: res_d.illegal = 1'b1;
    endcase
  end

  generate
    if (OUT_REG != 0) begin : g_reg
      load_res_t res_q;

      // Output stage: one cycle of latency, reset drops the in-flight result.
      always_ff @(posedge clk) begin
        if (rst) res_q <= '0;
        else     res_q <= res_d;
      end

      assign opt_data = res_q.data;
      assign illegal  = res_q.illegal;
    end else begin : g_comb
      // clk/rst are intentionally unused in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign opt_data = res_d.data;
      assign illegal  = res_d.illegal;
    end
  endgenerate

endmodule

// File: tb/tb_data_ext.sv
module tb_data_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  opcode = 3'b010;
  logic [31:0] in_data = 32'h0;
  logic [31:0] c_data, r_data;
  logic        c_ill, r_ill;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_ext #(.OUT_REG(0)) u_comb (
    .clk(clk), .rst(rst), .opcode(opcode), .in_data(in_data),
    .opt_data(c_data), .illegal(c_ill)
  );

  data_ext #(.OUT_REG(1)) u_reg (
    .clk(clk), .rst(rst), .opcode(opcode), .in_data(in_data),
    .opt_data(r_data), .illegal(r_ill)
  );

  // Reference: arithmetic view of the load rules.
  function automatic void ref_ext(input logic [2:0] op, input logic [31:0] d,
                                  output logic [31:0] ev, output logic ei);
    longint v;
    ei = 1'b0;
    case (op)
      3'd0: begin v = d % 256;   if (v >= 128)   v = v - 256;   ev = 32'(v); end
      3'd1: begin v = d % 65536; if (v >= 32768) v = v - 65536; ev = 32'(v); end
      3'd2: ev = d;
      3'd4: ev = d % 256;
      3'd5: ev = d % 65536;
      default: begin ev = 32'h0; ei = 1'b1; end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t dir_vecs[$] = '{
    '{3'b000, 32'h1234_8086, 32'hFFFF_FF86, 1'b0},
    '{3'b001, 32'h1234_8086, 32'hFFFF_8086, 1'b0},
    '{3'b010, 32'h1234_8086, 32'h1234_8086, 1'b0},
    '{3'b100, 32'h1234_8086, 32'h0000_0086, 1'b0},
    '{3'b101, 32'h1234_8086, 32'h0000_8086, 1'b0},
    '{3'b000, 32'hABCD_7F7F, 32'h0000_007F, 1'b0},
    '{3'b001, 32'hABCD_7F7F, 32'h0000_7F7F, 1'b0},
    '{3'b100, 32'hABCD_7F7F, 32'h0000_007F, 1'b0},
    '{3'b101, 32'hABCD_7F7F, 32'h0000_7F7F, 1'b0},
    '{3'b100, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0},
    '{3'b101, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0},
    '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
    '{3'b000, 32'h0,         32'h0,         1'b0},
    '{3'b001, 32'h0,         32'h0,         1'b0},
    '{3'b010, 32'h0,         32'h0,         1'b0},
    '{3'b100, 32'h0,         32'h0,         1'b0},
    '{3'b101, 32'h0,         32'h0,         1'b0},
    '{3'b011, 32'hDEAD_BEEF, 32'h0,         1'b1},
    '{3'b110, 32'hDEAD_BEEF, 32'h0,         1'b1},
    '{3'b111, 32'hDEAD_BEEF, 32'h0,         1'b1}
  };

  initial begin
    logic [31:0] ev;
    logic        ei;
    logic [31:0] exp_q;
    logic        ill_q;

    // Combinational build: directed table from the load rules.
    #2;
    foreach (dir_vecs[i]) begin
      opcode  = dir_vecs[i].op;
      in_data = dir_vecs[i].d;
      #1;
      check($sformatf("dir_data[%0d]", i), c_data, dir_vecs[i].exp);
      check($sformatf("dir_ill[%0d]", i), 32'(c_ill), 32'(dir_vecs[i].ill));
    end

    // Combinational build: random sweep against the reference model.
    for (int i = 0; i < 60; i++) begin
      opcode  = 3'($urandom_range(7, 0));
      in_data = $urandom;
      #1;
      ref_ext(opcode, in_data, ev, ei);
      check("rnd_comb_data", c_data, ev);
      check("rnd_comb_ill", 32'(c_ill), 32'(ei));
    end

    // Registered build: reset held two cycles, comb build keeps tracking.
    edge_sample();
    rst = 1'b1; opcode = 3'b010; in_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      check("rst_reg_data", r_data, 32'h0);
      check("rst_reg_ill", 32'(r_ill), 32'h0);
      check("rst_comb_tracks", c_data, 32'hDEAD_BEEF);
    end
    opcode = 3'b111;
    #1;
    check("rst_reg_ill_bad_op", 32'(r_ill), 32'h0);
    check("rst_comb_ill", 32'(c_ill), 32'h1);

    // First load after reset shows up exactly one edge later.
    rst = 1'b0; opcode = 3'b001; in_data = 32'h0000_8001;
    #1;
    check("lat_before_edge", r_data, 32'h0);
    edge_sample();
    check("lat_after_edge", r_data, 32'hFFFF_8001);
    check("lat_after_edge_ill", 32'(r_ill), 32'h0);

    // Back-to-back random loads: each result lags its inputs by one cycle.
    for (int i = 0; i < 30; i++) begin
      opcode  = 3'($urandom_range(7, 0));
      in_data = $urandom;
      ref_ext(opcode, in_data, exp_q, ill_q);
      edge_sample();
      check("b2b_data", r_data, exp_q);
      check("b2b_ill", 32'(r_ill), 32'(ill_q));
    end

    // Mid-stream reset on LW traffic drops exactly that cycle's result.
    for (int i = 0; i < 8; i++) begin
      opcode  = 3'b010;
      in_data = $urandom | 32'h1;
      rst     = (i == 3);
      exp_q   = (i == 3) ? 32'h0 : in_data;
      edge_sample();
      check($sformatf("mid_rst_data[%0d]", i), r_data, exp_q);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
